multiplier_datapath_taint_track: RTL and testbench
==================================================

# multiplier_datapath_taint_track

Datapath stage of the sequential shift-add multiplier, directly downstream of the multiplier control FSM. It holds the multiplicand, multiplier and result shift registers and executes the control strobes (`mdld`, `mrld`, `rsclear`, `rsload`, `rsshr`). It returns the multiplier register to the control for bit selection and produces the product. Every data register carries a bitwise taint shadow, so information flow from tainted operands or tainted control strobes is tracked through the arithmetic.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits; product is 2·WIDTH.

Ports:
- `clk`  input  1  clock, all state updates on the rising edge
- `rst`  input  1  asynchronous active-low reset (0 = reset)
- `multiplicand` / `multiplicand_t`  input  WIDTH  operand A and its taint
- `multiplier` / `multiplier_t`  input  WIDTH  operand B and its taint
- `mdld` / `mdld_t`  input  1  load multiplicand register (MD), and its taint
- `mrld` / `mrld_t`  input  1  load multiplier register (MR), and its taint
- `rsclear` / `rsclear_t`  input  1  clear result register (RS), and its taint
- `rsload` / `rsload_t`  input  1  add MD into the RS upper half, and its taint
- `rsshr` / `rsshr_t`  input  1  shift RS right by one, and its taint
- `multiplierReg` / `multiplierReg_t`  output  WIDTH  MR contents and taint, to the control
- `product` / `product_t`  output  2·WIDTH  RS[2W-1:0] and its taint

## Operation
- Registers:
  - MD[W-1:0], MR[W-1:0], RS[2W:0].
  - RS[2W] is the carry bit.
  - Each register has an equal-width `_t` shadow.
- Data updates:
  - `mdld`: MD <= `multiplicand`.
  - `mrld`: MR <= `multiplier`.
- RS priority, one action per cycle: `rsclear` > `rsload` > `rsshr`.
  - `rsclear`: RS <= 0.
  - `rsload`: RS[2W:W] <= RS[2W-1:W] + MD, a (W+1)-bit sum. RS[W-1:0] is unchanged.
  - `rsshr`: RS <= {1'b0, RS[2W:1]}.
- MR is never shifted. The control indexes it by its own bit counter.
- Taint propagation, value-driven (strobe = 1):
  - MD_t / MR_t are loaded with the operand taint.
  - Sum bit i taint = OR of MD_t[0..i] and RS_t[W..W+i]. The carry taint is the OR of all of these.
  - Shift moves RS_t with the data, inserting 0 at the top.
  - Clear zeroes RS_t.
- Taint propagation, strobe-tainted (`x_t` = 1, whatever the value of `x`):
  - Each bit the strobe could modify becomes: new_t[i] = old_t[i] | cand_t[i] | (old[i] != cand[i]).
  - cand is the value the register would take with the strobe asserted.
  - The data register itself follows the untainted strobe value.
- Taint is sticky. It clears only by reset, or by a value-driven untainted load/clear.

## Timing
- Reset (`rst` = 0, asynchronous, any cycle including mid-multiply): MD, MR, RS and all `_t` shadows go to 0. `product`, `product_t`, `multiplierReg` and `multiplierReg_t` read 0.
- Strobes are sampled at the rising edge. The effect is visible the following cycle.
- `multiplierReg` and `product` are direct register outputs, with no combinational path from inputs.
- Full multiply with the control sequence INIT, (SHIFT, LOAD|NOP)×W, FINAL: 2W+2 cycles from INIT.
  - W loads/nops and W+1 shifts occur; the first shift acts on a cleared RS.
  - `product` is valid the cycle after the FINAL edge and holds until the next `rsclear`/`rsload`/`rsshr`.
- Carry-out of a `rsload` lands in RS[2W] and is shifted down by the next `rsshr`. No overflow is possible for W-bit operands.

## Configuration
- `MULT_DP_TAINT_EN` defined: shadow registers and taint logic are compiled in, as described above.
- `MULT_DP_TAINT_EN` undefined:
  - No shadow registers.
  - All `_t` outputs are tied to 0 and `_t` inputs are ignored.
  - Data behaviour is identical in both builds.

## Test plan
- Reset mid-multiply: assert `rst` = 0 between two strobes → all outputs 0 immediately (asynchronous); they stay 0 until strobes resume after release.
- W = 4, 13×11, no taint, standard control sequence → `multiplierReg` = 0xB, `product` = 143 (0x8F), `product_t` = 0.
- W = 4, 15×15 (carry path) → `product` = 225 (0xE1), RS[2W] = 0 after FINAL.
- W = 4, `multiplicand_t` = 0x8, MD = 8, MR = 1 → `product` = 0x08, `product_t` = 0x18.
- Tainted strobes, expected taint set only where a bit could change:
  - `mdld` = 0, `mdld_t` = 1, MD = 0x6, `multiplicand` = 0x5 → MD unchanged, MD_t = 0x3.
  - `rsload_t` = 1 with MD = 0 → RS_t unchanged (0).
- `rsclear` and `rsload` asserted in the same cycle → RS = 0 and RS_t = 0; the load is ignored.

Source files
------------

// File: rtl/multiplier_datapath_taint_track.sv
// Shift-add multiplier datapath (MD, MR, RS registers) with bitwise taint shadows.
// Taint shadows and propagation logic exist only when MULT_DP_TAINT_EN is defined.
module multiplier_datapath_taint_track #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplicand_t,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplier_t,
  input  logic                 mdld,
  input  logic                 mdld_t,
  input  logic                 mrld,
  input  logic                 mrld_t,
  input  logic                 rsclear,
  input  logic                 rsclear_t,
  input  logic                 rsload,
  input  logic                 rsload_t,
  input  logic                 rsshr,
  input  logic                 rsshr_t,
  output logic [WIDTH-1:0]     multiplierReg,
  output logic [WIDTH-1:0]     multiplierReg_t,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_t
);

  localparam int unsigned RW = 2 * WIDTH + 1;
  localparam int unsigned NS = 3;

  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [RW-1:0]    rs_q, rs_d;
  logic [NS-1:0]    rs_s;

  // RS next value for a strobe vector {rsclear, rsload, rsshr}; clear > load > shift
  function automatic logic [RW-1:0] rs_step(input logic [NS-1:0]  s,
                                            input logic [RW-1:0]  rs,
                                            input logic [WIDTH-1:0] md);
    logic [WIDTH:0]  sum;
    logic [RW-1:0]   r;
    sum = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};
    if (s[2])      r = '0;
    else if (s[1]) r = {sum, rs[WIDTH-1:0]};
    else if (s[0]) r = {1'b0, rs[RW-1:1]};
    else           r = rs;
    return r;
  endfunction

  always_comb begin
    rs_s = {rsclear, rsload, rsshr};
    md_d = mdld ? multiplicand : md_q;
    mr_d = mrld ? multiplier : mr_q;
    rs_d = rs_step(rs_s, rs_q, md_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_q <= '0;
      mr_q <= '0;
      rs_q <= '0;
    end else begin
      md_q <= md_d;
      mr_q <= mr_d;
      rs_q <= rs_d;
    end
  end

  assign multiplierReg = mr_q;
  assign product       = rs_q[2*WIDTH-1:0];

`ifdef MULT_DP_TAINT_EN
  logic [WIDTH-1:0] md_t_q, md_t_d;
  logic [WIDTH-1:0] mr_t_q, mr_t_d;
  logic [RW-1:0]    rs_t_q, rs_t_d;
  logic [NS-1:0]    rs_s_t;

  // Taint of the RS outcome for a strobe vector; sum bit i depends on operand bits 0..i
  function automatic logic [RW-1:0] rs_taint_step(input logic [NS-1:0]    s,
                                                  input logic [RW-1:0]    rs_t,
                                                  input logic [WIDTH-1:0] md_t);
    logic          acc;
    logic [RW-1:0] r;
    acc = 1'b0;
    r   = rs_t;
    if (s[2]) begin
      r = '0;
    end else if (s[1]) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        acc          = acc | md_t[i] | rs_t[WIDTH+i];
        r[WIDTH+i]   = acc;
      end
      r[RW-1] = acc;
    end else if (s[0]) begin
      r = {1'b0, rs_t[RW-1:1]};
    end
    return r;
  endfunction

  // A tainted strobe taints every bit whose value differs across its possible settings
  always_comb begin
    rs_s_t = {rsclear_t, rsload_t, rsshr_t};

    if (mdld_t)    md_t_d = md_t_q | multiplicand_t | (md_q ^ multiplicand);
    else if (mdld) md_t_d = multiplicand_t;
    else           md_t_d = md_t_q;

    if (mrld_t)    mr_t_d = mr_t_q | multiplier_t | (mr_q ^ multiplier);
    else if (mrld) mr_t_d = multiplier_t;
    else           mr_t_d = mr_t_q;

    rs_t_d = rs_taint_step(rs_s, rs_t_q, md_t_q);
    for (int c = 0; c < (1 << NS); c++) begin
      if (((NS'(c) ^ rs_s) & ~rs_s_t) == '0) begin
        rs_t_d = rs_t_d | rs_taint_step(NS'(c), rs_t_q, md_t_q)
                        | (rs_step(NS'(c), rs_q, md_q) ^ rs_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_t_q <= '0;
      mr_t_q <= '0;
      rs_t_q <= '0;
    end else begin
      md_t_q <= md_t_d;
      mr_t_q <= mr_t_d;
      rs_t_q <= rs_t_d;
    end
  end

  assign multiplierReg_t = mr_t_q;
  assign product_t       = rs_t_q[2*WIDTH-1:0];
`else
  logic unused_taint;
  assign unused_taint = ^{multiplicand_t, multiplier_t, mdld_t, mrld_t,
                          rsclear_t, rsload_t, rsshr_t};
  assign multiplierReg_t = '0;
  assign product_t       = '0;
`endif

endmodule

// File: tb/tb_multiplier_datapath_taint_track.sv
// Directed bench for multiplier_datapath_taint_track (W = 4); taint expectations
// follow whether MULT_DP_TAINT_EN is defined.
module tb_multiplier_datapath_taint_track;

  localparam int unsigned W = 4;
`ifdef MULT_DP_TAINT_EN
  localparam bit TAINT_ON = 1'b1;
`else
  localparam bit TAINT_ON = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [W-1:0]   multiplicand, multiplicand_t, multiplier, multiplier_t;
  logic           mdld, mdld_t, mrld, mrld_t;
  logic           rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
  logic [W-1:0]   multiplierReg, multiplierReg_t;
  logic [2*W-1:0] product, product_t;

  int n_checks;
  int n_fail;

  multiplier_datapath_taint_track #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .multiplicand    (multiplicand),
    .multiplicand_t  (multiplicand_t),
    .multiplier      (multiplier),
    .multiplier_t    (multiplier_t),
    .mdld            (mdld),
    .mdld_t          (mdld_t),
    .mrld            (mrld),
    .mrld_t          (mrld_t),
    .rsclear         (rsclear),
    .rsclear_t       (rsclear_t),
    .rsload          (rsload),
    .rsload_t        (rsload_t),
    .rsshr           (rsshr),
    .rsshr_t         (rsshr_t),
    .multiplierReg   (multiplierReg),
    .multiplierReg_t (multiplierReg_t),
    .product         (product),
    .product_t       (product_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] texp(input logic [7:0] v);
    return TAINT_ON ? v : 8'h00;
  endfunction

  // s / st = {mdld, mrld, rsclear, rsload, rsshr}; one edge, then strobes drop
  task automatic strobe(input logic [4:0] s, input logic [4:0] st);
    {mdld, mrld, rsclear, rsload, rsshr} = s;
    {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = st;
    @(posedge clk);
    #1;
    {mdld, mrld, rsclear, rsload, rsshr} = 5'b0;
    {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = 5'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Control sequence INIT, (SHIFT, LOAD|NOP) x W, FINAL
  task automatic multiply(input logic [3:0] a, input logic [3:0] at,
                          input logic [3:0] b, input logic [3:0] bt);
    multiplicand = a; multiplicand_t = at;
    multiplier = b;   multiplier_t = bt;
    strobe(5'b11100, 5'b0);
    for (int i = 0; i < 4; i++) begin
      strobe(5'b00001, 5'b0);
      strobe(b[i] ? 5'b00010 : 5'b00000, 5'b0);
    end
    strobe(5'b00001, 5'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (product !== 8'h00) begin n_fail++; $display("FAIL reset_product: got %h expected 00", product); end
    n_checks++;
    if (product_t !== 8'h00) begin n_fail++; $display("FAIL reset_product_t: got %h expected 00", product_t); end
    n_checks++;
    if (multiplierReg !== 4'h0) begin n_fail++; $display("FAIL reset_mr: got %h expected 0", multiplierReg); end
    n_checks++;
    if (multiplierReg_t !== 4'h0) begin n_fail++; $display("FAIL reset_mr_t: got %h expected 0", multiplierReg_t); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult_basic();
    do_reset();
    multiply(4'd13, 4'h0, 4'd11, 4'h0);
    n_checks++;
    if (multiplierReg !== 4'hB) begin n_fail++; $display("FAIL m13x11_mr: got %h expected b", multiplierReg); end
    n_checks++;
    if (product !== 8'h8F) begin n_fail++; $display("FAIL m13x11_product: got %h expected 8f", product); end
    n_checks++;
    if (product_t !== 8'h00) begin n_fail++; $display("FAIL m13x11_product_t: got %h expected 00", product_t); end
    strobe(5'b0, 5'b0);
    n_checks++;
    if (product !== 8'h8F) begin n_fail++; $display("FAIL m13x11_hold: got %h expected 8f", product); end
  endtask

  task automatic test_carry();
    do_reset();
    multiply(4'd15, 4'h0, 4'd15, 4'h0);
    n_checks++;
    if (product !== 8'hE1) begin n_fail++; $display("FAIL m15x15_product: got %h expected e1", product); end
    // an extra shift exposes RS[2W] in product[2W-1]
    strobe(5'b00001, 5'b0);
    n_checks++;
    if (product !== 8'h70) begin n_fail++; $display("FAIL m15x15_carry_bit: got %h expected 70", product); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    multiply(4'd3, 4'h0, 4'd5, 4'h0);
    n_checks++;
    if (product !== 8'h0F) begin n_fail++; $display("FAIL b2b_first: got %h expected 0f", product); end
    multiply(4'd7, 4'h0, 4'd6, 4'h0);
    n_checks++;
    if (product !== 8'h2A) begin n_fail++; $display("FAIL b2b_second: got %h expected 2a", product); end
    n_checks++;
    if (multiplierReg !== 4'h6) begin n_fail++; $display("FAIL b2b_mr: got %h expected 6", multiplierReg); end
  endtask

  task automatic test_operand_taint();
    do_reset();
    multiply(4'd8, 4'h8, 4'd1, 4'h5);
    n_checks++;
    if (product !== 8'h08) begin n_fail++; $display("FAIL optaint_product: got %h expected 08", product); end
    n_checks++;
    if (product_t !== texp(8'h18)) begin n_fail++; $display("FAIL optaint_product_t: got %h expected %h", product_t, texp(8'h18)); end
    n_checks++;
    if (multiplierReg_t !== texp(8'h05)) begin n_fail++; $display("FAIL optaint_mr_t: got %h expected %h", multiplierReg_t, texp(8'h05)); end
  endtask

  task automatic test_tainted_mdld();
    do_reset();
    multiplicand = 4'h6; multiplicand_t = 4'h0;
    strobe(5'b10000, 5'b0);
    multiplicand = 4'h5;
    strobe(5'b00000, 5'b10000);
`ifdef MULT_DP_TAINT_EN
    n_checks++;
    if (dut.md_t_q !== 4'h3) begin n_fail++; $display("FAIL mdld_t_shadow: got %h expected 3", dut.md_t_q); end
`endif
    strobe(5'b00010, 5'b0);
    n_checks++;
    if (product !== 8'h60) begin n_fail++; $display("FAIL mdld_t_md_kept: got %h expected 60", product); end
    n_checks++;
    if (product_t !== texp(8'hF0)) begin n_fail++; $display("FAIL mdld_t_sum_t: got %h expected %h", product_t, texp(8'hF0)); end
  endtask

  task automatic test_tainted_rs();
    do_reset();
    strobe(5'b00000, 5'b00010);
    n_checks++;
    if (product !== 8'h00) begin n_fail++; $display("FAIL rsload_t_md0_product: got %h expected 00", product); end
    n_checks++;
    if (product_t !== 8'h00) begin n_fail++; $display("FAIL rsload_t_md0_taint: got %h expected 00", product_t); end
    multiplicand = 4'h5; multiplicand_t = 4'h0;
    strobe(5'b10000, 5'b0);
    strobe(5'b00010, 5'b0);
    strobe(5'b00000, 5'b00001);
    n_checks++;
    if (product !== 8'h50) begin n_fail++; $display("FAIL rsshr_t_product: got %h expected 50", product); end
    n_checks++;
    if (product_t !== texp(8'h78)) begin n_fail++; $display("FAIL rsshr_t_taint: got %h expected %h", product_t, texp(8'h78)); end
  endtask

  task automatic test_priority();
    do_reset();
    multiplicand = 4'h9; multiplicand_t = 4'hF;
    strobe(5'b10000, 5'b0);
    strobe(5'b00010, 5'b0);
    n_checks++;
    if (product_t !== texp(8'hF0)) begin n_fail++; $display("FAIL prio_pre_taint: got %h expected %h", product_t, texp(8'hF0)); end
    strobe(5'b00110, 5'b0);
    n_checks++;
    if (product !== 8'h00) begin n_fail++; $display("FAIL prio_clr_load_product: got %h expected 00", product); end
    n_checks++;
    if (product_t !== 8'h00) begin n_fail++; $display("FAIL prio_clr_load_taint: got %h expected 00", product_t); end
    strobe(5'b00011, 5'b0);
    n_checks++;
    if (product !== 8'h90) begin n_fail++; $display("FAIL prio_load_shr: got %h expected 90", product); end
    strobe(5'b00101, 5'b0);
    n_checks++;
    if (product !== 8'h00) begin n_fail++; $display("FAIL prio_clr_shr: got %h expected 00", product); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    multiplicand = 4'd13; multiplicand_t = 4'h0;
    multiplier = 4'd11;   multiplier_t = 4'h0;
    strobe(5'b11100, 5'b0);
    strobe(5'b00001, 5'b0);
    strobe(5'b00010, 5'b0);
    n_checks++;
    if (product !== 8'hD0) begin n_fail++; $display("FAIL mid_partial: got %h expected d0", product); end
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (product !== 8'h00) begin n_fail++; $display("FAIL mid_async_product: got %h expected 00", product); end
    n_checks++;
    if (multiplierReg !== 4'h0) begin n_fail++; $display("FAIL mid_async_mr: got %h expected 0", multiplierReg); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (product !== 8'h00) begin n_fail++; $display("FAIL mid_held_product: got %h expected 00", product); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (multiplierReg !== 4'h0) begin n_fail++; $display("FAIL mid_released_mr: got %h expected 0", multiplierReg); end
    strobe(5'b01000, 5'b0);
    n_checks++;
    if (multiplierReg !== 4'hB) begin n_fail++; $display("FAIL mid_resume_mr: got %h expected b", multiplierReg); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    multiplicand = '0; multiplicand_t = '0;
    multiplier = '0;   multiplier_t = '0;
    {mdld, mrld, rsclear, rsload, rsshr} = 5'b0;
    {mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t} = 5'b0;

    test_reset();
    test_mult_basic();
    test_carry();
    test_back_to_back();
    test_operand_taint();
    test_tainted_mdld();
    test_tainted_rs();
    test_priority();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
